// File: rtl/mem_access_stage_pkg.sv
// Shared types for the EX/MEM stage and its data-memory handshake.
// Optional MEM_TIMEOUT_EN adds the ACCESS abort path.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } memState_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

  typedef struct packed {
    logic        regWrite;
    logic        memToReg;
    logic        memRead;
    logic        memWrite;
    logic [31:0] execOut;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
  } exMem_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port between the EX/MEM stage and memory.
// Address, data and direction are held stable while mem_req is high.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_fsm.sv
// IDLE/ACCESS/RESP handshake controller for the EX/MEM stage.
// MEM_TIMEOUT_EN adds a wait counter that aborts a stuck access.
module mem_handshake_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      memOp,
  input  logic      ack,
  output memState_t state,
  output logic      memReq,
  output logic      stall,
  output logic      timeoutHit,
  output logic      memError
);

  memState_t nextState;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] waitCnt;
  logic       errReg;

  // Counter rests at zero outside ACCESS, so it is clear on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
      errReg  <= 1'b0;
    end else begin
      waitCnt <= (state == ST_ACCESS) ? waitCnt + 8'd1 : '0;
      errReg  <= timeoutHit;
    end
  end

  assign memError = errReg;
`else
  logic unusedCfg;
  assign unusedCfg = ^32'(TIMEOUT_CYCLES);
  assign memError  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = state;
    memReq     = 1'b0;
    stall      = 1'b0;
    timeoutHit = 1'b0;
    unique case (state)
      ST_ACCESS: begin
        memReq = 1'b1;
        stall  = 1'b1;
        if (ack) begin
          nextState = ST_RESP;
`ifdef MEM_TIMEOUT_EN
        end else if (waitCnt == LAST) begin
          nextState  = ST_RESP;
          timeoutHit = 1'b1;
`endif
        end
      end
      ST_IDLE, ST_RESP: begin
        nextState = memOp ? ST_ACCESS : ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus data-memory access stage.
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite_EX,
  input  logic                MemToReg_EX,
  input  logic                MemRead_EX,
  input  logic                MemWrite_EX,
  input  logic [31:0]         execution_out_EX,
  input  logic [31:0]         WriteData_EX,
  input  logic [4:0]          WriteReg_EX,
  mem_access_stage_if.master  mem,
  output logic                stall_MEM,
  output logic                RegWrite_MEM,
  output logic                MemToReg_MEM,
  output logic [31:0]         execution_out_MEM,
  output logic [31:0]         ReadData_MEM,
  output logic [4:0]          WriteReg_MEM,
  output logic                mem_error
);

  exMem_t    stg;
  memState_t state;
  logic      memReq;
  logic      timeoutHit;
  logic      inAccess;
  logic      readAck;

  mem_handshake_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .memOp      (MemRead_EX | MemWrite_EX),
    .ack        (mem.mem_ack),
    .state      (state),
    .memReq     (memReq),
    .stall      (stall_MEM),
    .timeoutHit (timeoutHit),
    .memError   (mem_error)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '0;
    end else if (!stall_MEM) begin
      stg <= '{
        regWrite:  RegWrite_EX,
        memToReg:  MemToReg_EX,
        memRead:   MemRead_EX,
        memWrite:  MemWrite_EX,
        execOut:   execution_out_EX,
        writeData: WriteData_EX,
        writeReg:  WriteReg_EX
      };
    end
  end

  assign inAccess = (state == ST_ACCESS);
  // Read+write together behaves as a store, so no load data.
  assign readAck  = inAccess & mem.mem_ack
                  & stg.memRead & ~stg.memWrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          ReadData_MEM <= '0;
    else if (readAck)    ReadData_MEM <= mem.mem_rdata;
    else if (timeoutHit) ReadData_MEM <= TIMEOUT_FILL;
  end

  assign mem.mem_req   = memReq;
  assign mem.mem_we    = stg.memWrite;
  assign mem.mem_addr  = stg.execOut;
  assign mem.mem_wdata = stg.writeData;

  assign RegWrite_MEM      = stg.regWrite & ~inAccess & ~mem_error;
  assign MemToReg_MEM      = stg.memToReg & ~inAccess;
  assign execution_out_MEM = stg.execOut;
  assign WriteReg_MEM      = stg.writeReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite_EX, MemToReg_EX;
  logic        MemRead_EX, MemWrite_EX;
  logic [31:0] execution_out_EX, WriteData_EX;
  logic [4:0]  WriteReg_EX;
  logic        stall_MEM, RegWrite_MEM, MemToReg_MEM;
  logic [31:0] execution_out_MEM, ReadData_MEM;
  logic [4:0]  WriteReg_MEM;
  logic        mem_error;

  int nCmp = 0;
  int nBad = 0;

  mem_access_stage_if memBus ();

  mem_access_stage dut (
    .clk               (clk),
    .reset             (reset),
    .RegWrite_EX       (RegWrite_EX),
    .MemToReg_EX       (MemToReg_EX),
    .MemRead_EX        (MemRead_EX),
    .MemWrite_EX       (MemWrite_EX),
    .execution_out_EX  (execution_out_EX),
    .WriteData_EX      (WriteData_EX),
    .WriteReg_EX       (WriteReg_EX),
    .mem               (memBus),
    .stall_MEM         (stall_MEM),
    .RegWrite_MEM      (RegWrite_MEM),
    .MemToReg_MEM      (MemToReg_MEM),
    .execution_out_MEM (execution_out_MEM),
    .ReadData_MEM      (ReadData_MEM),
    .WriteReg_MEM      (WriteReg_MEM),
    .mem_error         (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r,
                       input logic mr, input logic mw,
                       input logic [31:0] ex, input logic [31:0] wd,
                       input logic [4:0] wr);
    RegWrite_EX = rw; MemToReg_EX = m2r;
    MemRead_EX = mr; MemWrite_EX = mw;
    execution_out_EX = ex; WriteData_EX = wd; WriteReg_EX = wr;
  endtask

  task automatic test_reset();
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL rst_req got %0h want 0", memBus.mem_req); end
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL rst_stall got %0h want 0", stall_MEM); end
    nCmp++; if (RegWrite_MEM !== 1'b0) begin nBad++; $display("FAIL rst_regwrite got %0h want 0", RegWrite_MEM); end
    nCmp++; if (execution_out_MEM !== 32'h0) begin nBad++; $display("FAIL rst_exec got %h want 0", execution_out_MEM); end
    nCmp++; if (ReadData_MEM !== 32'h0) begin nBad++; $display("FAIL rst_rdata got %h want 0", ReadData_MEM); end
    nCmp++; if (mem_error !== 1'b0) begin nBad++; $display("FAIL rst_err got %0h want 0", mem_error); end
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3);
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'hFFFF;
    step();
    memBus.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    nCmp++; if (RegWrite_MEM !== 1'b1) begin nBad++; $display("FAIL alu_regwrite got %0h want 1", RegWrite_MEM); end
    nCmp++; if (execution_out_MEM !== 32'h10) begin nBad++; $display("FAIL alu_exec got %h want 10", execution_out_MEM); end
    nCmp++; if (WriteReg_MEM !== 5'd3) begin nBad++; $display("FAIL alu_wreg got %0d want 3", WriteReg_MEM); end
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL alu_stall got %0h want 0", stall_MEM); end
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL alu_req got %0h want 0", memBus.mem_req); end
    nCmp++; if (ReadData_MEM !== 32'h0) begin nBad++; $display("FAIL alu_stray_ack got %h want 0", ReadData_MEM); end
    step();
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      nCmp++; if (stall_MEM !== 1'b1) begin nBad++; $display("FAIL load_stall%0d got %0h want 1", i, stall_MEM); end
      nCmp++; if (RegWrite_MEM !== 1'b0) begin nBad++; $display("FAIL load_bubble%0d got %0h want 0", i, RegWrite_MEM); end
      nCmp++; if (memBus.mem_addr !== 32'h40) begin nBad++; $display("FAIL load_addr%0d got %h want 40", i, memBus.mem_addr); end
      if (i == 3) begin memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h1234; end
      step();
    end
    memBus.mem_ack = 1'b0;
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL load_resp_stall got %0h want 0", stall_MEM); end
    nCmp++; if (ReadData_MEM !== 32'h1234) begin nBad++; $display("FAIL load_rdata got %h want 1234", ReadData_MEM); end
    nCmp++; if (RegWrite_MEM !== 1'b1) begin nBad++; $display("FAIL load_regwrite got %0h want 1", RegWrite_MEM); end
    nCmp++; if (MemToReg_MEM !== 1'b1) begin nBad++; $display("FAIL load_m2r got %0h want 1", MemToReg_MEM); end
    nCmp++; if (WriteReg_MEM !== 5'd5) begin nBad++; $display("FAIL load_wreg got %0d want 5", WriteReg_MEM); end
    step();
  endtask

  task automatic test_store(input logic both, input logic [31:0] wd);
    drive(1'b0, 1'b0, both, 1'b1, 32'h80, wd, 5'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    nCmp++; if (memBus.mem_req !== 1'b1) begin nBad++; $display("FAIL st_req got %0h want 1", memBus.mem_req); end
    nCmp++; if (memBus.mem_we !== 1'b1) begin nBad++; $display("FAIL st_we got %0h want 1", memBus.mem_we); end
    nCmp++; if (memBus.mem_wdata !== wd) begin nBad++; $display("FAIL st_wdata got %h want %h", memBus.mem_wdata, wd); end
    nCmp++; if (memBus.mem_addr !== 32'h80) begin nBad++; $display("FAIL st_addr got %h want 80", memBus.mem_addr); end
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h9999;
    step();
    memBus.mem_ack = 1'b0;
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL st_resp_req got %0h want 0", memBus.mem_req); end
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL st_resp_stall got %0h want 0", stall_MEM); end
    nCmp++; if (ReadData_MEM !== 32'h1234) begin nBad++; $display("FAIL st_rdata_hold got %h want 1234", ReadData_MEM); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd6);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd7);
    nCmp++; if (memBus.mem_addr !== 32'h100) begin nBad++; $display("FAIL b2b_addr1 got %h want 100", memBus.mem_addr); end
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'hA1;
    step();
    memBus.mem_ack = 1'b0;
    nCmp++; if (ReadData_MEM !== 32'hA1) begin nBad++; $display("FAIL b2b_rdata1 got %h want a1", ReadData_MEM); end
    nCmp++; if (WriteReg_MEM !== 5'd6) begin nBad++; $display("FAIL b2b_wreg1 got %0d want 6", WriteReg_MEM); end
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL b2b_resp_req got %0h want 0", memBus.mem_req); end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    nCmp++; if (memBus.mem_req !== 1'b1) begin nBad++; $display("FAIL b2b_req2 got %0h want 1", memBus.mem_req); end
    nCmp++; if (memBus.mem_addr !== 32'h104) begin nBad++; $display("FAIL b2b_addr2 got %h want 104", memBus.mem_addr); end
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'hB2;
    step();
    memBus.mem_ack = 1'b0;
    nCmp++; if (ReadData_MEM !== 32'hB2) begin nBad++; $display("FAIL b2b_rdata2 got %h want b2", ReadData_MEM); end
    nCmp++; if (WriteReg_MEM !== 5'd7) begin nBad++; $display("FAIL b2b_wreg2 got %0d want 7", WriteReg_MEM); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    nCmp++; if (memBus.mem_req !== 1'b1) begin nBad++; $display("FAIL rmid_req_before got %0h want 1", memBus.mem_req); end
    #2 reset = 1'b0;
    #1;
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL rmid_req got %0h want 0", memBus.mem_req); end
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL rmid_stall got %0h want 0", stall_MEM); end
    nCmp++; if (memBus.mem_addr !== 32'h0) begin nBad++; $display("FAIL rmid_addr got %h want 0", memBus.mem_addr); end
    nCmp++; if (ReadData_MEM !== 32'h0) begin nBad++; $display("FAIL rmid_rdata got %h want 0", ReadData_MEM); end
    nCmp++; if (WriteReg_MEM !== 5'd0) begin nBad++; $display("FAIL rmid_wreg got %0d want 0", WriteReg_MEM); end
    step();
    reset = 1'b1;
    step();
    nCmp++; if (memBus.mem_req !== 1'b0) begin nBad++; $display("FAIL rmid_idle_req got %0h want 0", memBus.mem_req); end
    nCmp++; if (stall_MEM !== 1'b0) begin nBad++; $display("FAIL rmid_idle_stall got %0h want 0", stall_MEM); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      nCmp++; if (stall_MEM !== 1'b1) begin nBad++; $display("FAIL to_stall%0d got %0h want 1", i, stall_MEM); end
      step();
    end
    nCmp++; if (mem_error !== 1'b1) begin nBad++; $display("FAIL to_err got %0h want 1", mem_error); end
    nCmp++; if (ReadData_MEM !== 32'hDEADBEEF) begin nBad++; $display("FAIL to_rdata got %h want deadbeef", ReadData_MEM); end
    nCmp++; if (RegWrite_MEM !== 1'b0) begin nBad++; $display("FAIL to_regwrite got %0h want 0", RegWrite_MEM); end
    step();
    nCmp++; if (mem_error !== 1'b0) begin nBad++; $display("FAIL to_err_pulse got %0h want 0", mem_error); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    memBus.mem_ack = 1'b0;
    memBus.mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_alu();
    test_load();
    test_store(1'b0, 32'hAA);
    test_store(1'b1, 32'h55);
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
